// File: rtl/mult8_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult8_seq_pkg
// Description : Shared state encodings, step constants and the nibble-shift
//               table for the sequential 8x8 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LAST = 2'd3;

  // Left shift applied to each 4x4 partial product, indexed by step.
  function automatic logic [3:0] nib_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult8_seq_bitmul.sv
`default_nettype none
// ============================================================================
// Module      : Bit_multiplyer
// Description : Purely combinational 4x4 unsigned array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module Bit_multiplyer (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] w_row [4];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_row
      // One AND row of the array, pre-shifted to its bit weight.
      assign w_row[i] = b[i] ? ({4'b0000, a} << i) : 8'h00;
    end
  endgenerate

  assign p = w_row[0] + w_row[1] + w_row[2] + w_row[3];

endmodule
`default_nettype wire

// File: rtl/mult8_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult8_seq
// Description : Sequential 8x8 unsigned multiply / multiply-accumulate using a
//               single 4x4 multiplier over four cycles, with valid/ready
//               handshakes on both sides and a sticky wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mult8_seq
  import mult8_seq_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] p,
  output logic             ovf,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_step;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [ACC_W-1:0] r_p;
  logic             r_ovf;
  logic             r_out_valid;

  logic [3:0]       w_na;
  logic [3:0]       w_nb;
  logic [7:0]       w_pp;
  logic [3:0]       w_shift;
  logic [ACC_W:0]   w_addend;
  logic [ACC_W:0]   w_sum;

  // Operand nibbles come only from registers, so in_* never reaches p
  // combinationally.
  assign w_na    = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nb    = r_step[1] ? r_b[7:4] : r_b[3:0];
  assign w_shift = nib_shift(r_step);

  Bit_multiplyer u_mul (
    .a (w_na),
    .b (w_nb),
    .p (w_pp)
  );

  // One extra bit captures the carry out of the accumulator.
  assign w_addend = {{(ACC_W + 1 - 8){1'b0}}, w_pp} << w_shift;
  assign w_sum    = {1'b0, r_p} + w_addend;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, four MUL steps, hold in DONE until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)            w_state_nxt = MUL;
      MUL:     if (r_step == STEP_LAST) w_state_nxt = DONE;
      DONE:    if (out_ready)           w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, accumulation, overflow tracking and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= 2'd0;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_p         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_step <= 2'd0;
            if (!acc_en) begin
              r_p   <= '0;
              r_ovf <= 1'b0;
            end
          end
        end
        MUL: begin
          r_p    <= w_sum[ACC_W-1:0];
          r_step <= r_step + 2'd1;
          if (w_sum[ACC_W])        r_ovf       <= 1'b1;
          if (r_step == STEP_LAST) r_out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
